// File: rtl/mac_array_gen.sv
// N x N matrix multiply-accumulate engine: C = A*B or C += A*B, one k-step per enabled cycle.
// Signed/unsigned operands, global clock enable, sticky per-run overflow flag.
module mac_array_gen #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                accumulate,
  input  logic                signed_mode,
  input  logic [N*N*DW-1:0]   a,
  input  logic [N*N*DW-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [N*N*AW-1:0]   c
);

  localparam int KW = $clog2(N);

  typedef enum logic {IDLE, COMPUTE} state_t;

  state_t              state_reg, state_next;
  logic [KW-1:0]       k_reg;
  logic [N*N*DW-1:0]   a_reg, b_reg;
  logic                sm_reg;
  logic                done_reg;
  logic                ovf_reg;
  logic [AW-1:0]       acc_reg [N*N];
  logic [N*N-1:0]      ovf_vec;
  logic                accept, step, last;

  assign last = (k_reg == KW'(N - 1));

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = COMPUTE;
          accept     = 1'b1;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else if (enable) state_reg <= state_next;
  end

  // Operand snapshot, step counter, done pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sm_reg   <= 1'b0;
      done_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (enable) begin
      done_reg <= step && last;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        sm_reg  <= signed_mode;
        k_reg   <= '0;
        ovf_reg <= 1'b0;
      end else if (step) begin
        k_reg   <= last ? '0 : k_reg + KW'(1);
        ovf_reg <= ovf_reg | (|ovf_vec);
      end
    end
  end

  for (genvar gi = 0; gi < N * N; gi++) begin : g_cell
    localparam int I = gi / N;
    localparam int J = gi % N;

    logic [DW-1:0]          a_el, b_el;
    logic signed [2*DW-1:0] prod_s;
    logic [2*DW-1:0]        prod_u;
    logic [AW-1:0]          ext;
    logic [AW:0]            sum;

    assign a_el   = a_reg[(I * N + int'(k_reg)) * DW +: DW];
    assign b_el   = b_reg[(int'(k_reg) * N + J) * DW +: DW];
    // Both operands widened to 2*DW first so the low 2*DW product bits are exact
    assign prod_s = $signed({{DW{a_el[DW-1]}}, a_el}) * $signed({{DW{b_el[DW-1]}}, b_el});
    assign prod_u = {{DW{1'b0}}, a_el} * {{DW{1'b0}}, b_el};

    if (AW > 2 * DW) begin : g_ext
      assign ext = sm_reg ? {{(AW - 2*DW){prod_s[2*DW-1]}}, prod_s}
                          : {{(AW - 2*DW){1'b0}}, prod_u};
    end else begin : g_noext
      assign ext = sm_reg ? prod_s : prod_u;
    end

    assign sum          = {1'b0, acc_reg[gi]} + {1'b0, ext};
    assign ovf_vec[gi]  = sm_reg ? ((acc_reg[gi][AW-1] == ext[AW-1]) &&
                                    (sum[AW-1] != acc_reg[gi][AW-1]))
                                 : sum[AW];

    always_ff @(posedge clk) begin
      if (!reset) begin
        acc_reg[gi] <= '0;
      end else if (enable) begin
        if (accept && !accumulate) acc_reg[gi] <= '0;
        else if (step)             acc_reg[gi] <= sum[AW-1:0];
      end
    end

    assign c[gi*AW +: AW] = acc_reg[gi];
  end

  assign busy     = (state_reg == COMPUTE);
  assign done     = done_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_mac_array_gen.sv
// Bench for mac_array_gen: vector table, hand-written timing/stall/reset sequences,
// and random runs checked against an integer-arithmetic matrix model (AW=32 and AW=16 instances).
module tb_mac_array_gen;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, start, accumulate, signed_mode;
  logic [127:0] a, b;
  logic         busy32, done32, ovf32, busy16, done16, ovf16;
  logic [511:0] c32;
  logic [255:0] c16;

  mac_array_gen #(.N(4), .DW(8), .AW(32)) u32 (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .accumulate(accumulate), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy32), .done(done32), .overflow(ovf32), .c(c32));

  mac_array_gen #(.N(4), .DW(8), .AW(16)) u16 (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .accumulate(accumulate), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy16), .done(done16), .overflow(ovf16), .c(c16));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef int mat_t [16];

  function automatic logic [127:0] pk8(input mat_t m);
    logic [127:0] r;
    for (int e = 0; e < 16; e++) r[e*8 +: 8] = m[e][7:0];
    return r;
  endfunction

  function automatic logic [511:0] pk32(input mat_t m);
    logic [511:0] r;
    for (int e = 0; e < 16; e++) r[e*32 +: 32] = m[e];
    return r;
  endfunction

  typedef struct packed {
    logic [127:0] va;
    logic [127:0] vb;
    logic         vacc;
    logic         vsm;
    logic [511:0] vc;
    logic         vovf;
  } vec_t;

  function automatic vec_t mkvec(input logic [127:0] va, input logic [127:0] vb,
                                 input logic vacc, input logic vsm,
                                 input logic [511:0] vc, input logic vovf);
    vec_t v;
    v.va = va; v.vb = vb; v.vacc = vacc; v.vsm = vsm; v.vc = vc; v.vovf = vovf;
    return v;
  endfunction

  // Reference model: plain integer matrix product, wrapped per width, overflow per add
  longint mref [2][16];
  logic   mov  [2];

  function automatic longint sv(input longint x, input longint lim);
    return (x >= lim / 2) ? x - lim : x;
  endfunction

  task automatic model_run(input logic [127:0] aa, input logic [127:0] bb,
                           input logic acc, input logic sm);
    logic [7:0] x, y;
    longint lim, p, pw, s, t;
    for (int w = 0; w < 2; w++) begin
      lim    = (w == 0) ? 64'h1_0000_0000 : 64'h1_0000;
      mov[w] = 1'b0;
      if (!acc) for (int e = 0; e < 16; e++) mref[w][e] = 0;
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            x  = aa[(i*4 + k)*8 +: 8];
            y  = bb[(k*4 + j)*8 +: 8];
            p  = sm ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
            pw = ((p % lim) + lim) % lim;
            s  = mref[w][i*4+j] + pw;
            if (!sm) begin
              if (s >= lim) mov[w] = 1'b1;
            end else begin
              t = sv(mref[w][i*4+j], lim) + sv(pw, lim);
              if (t >= lim / 2 || t < -(lim / 2)) mov[w] = 1'b1;
            end
            mref[w][i*4+j] = s % lim;
          end
        end
      end
    end
  endtask

  // One run with continuous enable; checks busy count, latency and done width
  task automatic run(input logic [127:0] aa, input logic [127:0] bb,
                     input logic acc, input logic sm, input string tag);
    int lat, bc;
    @(negedge clk);
    a = aa; b = bb; accumulate = acc; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = ~aa; b = ~bb; accumulate = ~acc; signed_mode = ~sm;
    lat = 0; bc = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy32) bc++;
      if (done32) break;
    end
    chk({tag, " latency"}, 64'(lat), 64'(N + 1));
    chk({tag, " busy_cycles"}, 64'(bc), 64'(N));
    $display("run %s acc=%0b sm=%0b lat=%0d ovf32=%0b ovf16=%0b", tag, acc, sm, lat, ovf32, ovf16);
    @(negedge clk);
    chk({tag, " done_width"}, 64'(done32), 64'd0);
  endtask

  mat_t ta  = '{5,2,7,1, 3,6,4,8, 9,0,2,5, 1,3,8,6};
  mat_t tbm = '{2,7,1,4, 5,0,6,3, 3,8,2,1, 4,1,9,5};
  mat_t tc  = '{45,92,40,38, 80,61,119,74, 44,84,58,63, 65,77,89,51};
  mat_t tc2, tff, tid, tm1, t255;
  vec_t tbl [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ra, rb;
    logic racc, rsm;
    int lat;
    logic seen;

    reset = 1'b0; enable = 1'b1; start = 1'b0; accumulate = 1'b0; signed_mode = 1'b0;
    a = '0; b = '0;
    for (int e = 0; e < 16; e++) begin
      tc2[e]  = 2 * tc[e];
      tff[e]  = 255;
      tid[e]  = (e / 4 == e % 4) ? 1 : 0;
      tm1[e]  = -1;
      t255[e] = 255;
    end
    tbl[0] = mkvec(pk8(ta),  pk8(tbm), 1'b0, 1'b0, pk32(tc),   1'b0);
    tbl[1] = mkvec(pk8(ta),  pk8(tbm), 1'b1, 1'b0, pk32(tc2),  1'b0);
    tbl[2] = mkvec(pk8(tff), pk8(tid), 1'b0, 1'b1, pk32(tm1),  1'b0);
    tbl[3] = mkvec(pk8(tff), pk8(tid), 1'b0, 1'b0, pk32(t255), 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 64'(busy32), 64'd0);
    chk("rst done", 64'(done32), 64'd0);
    chk("rst ovf",  64'(ovf32),  64'd0);
    chk("rst c32_nonzero", 64'(c32 != '0), 64'd0);
    chk("rst c16_nonzero", 64'(c16 != '0), 64'd0);
    reset = 1'b1;

    // Vector table
    for (int t = 0; t < 4; t++) begin
      run(tbl[t].va, tbl[t].vb, tbl[t].vacc, tbl[t].vsm, $sformatf("tbl%0d", t));
      for (int e = 0; e < 16; e++)
        chk($sformatf("tbl%0d c%0d", t, e), 64'(c32[e*32 +: 32]), 64'(tbl[t].vc[e*32 +: 32]));
      chk($sformatf("tbl%0d ovf", t), 64'(ovf32), 64'(tbl[t].vovf));
    end

    // Overflow on the 16-bit instance, then cleared by a clean run
    run(pk8(tff), pk8(tff), 1'b0, 1'b0, "ovf16");
    for (int e = 0; e < 16; e++)
      chk($sformatf("ovf16 c%0d", e), 64'(c16[e*16 +: 16]), 64'd63492);
    chk("ovf16 flag", 64'(ovf16), 64'd1);
    chk("ovf32 flag", 64'(ovf32), 64'd0);
    run(pk8(ta), pk8(tbm), 1'b0, 1'b0, "clean16");
    chk("clean16 flag", 64'(ovf16), 64'd0);
    for (int e = 0; e < 16; e++)
      chk($sformatf("clean16 c%0d", e), 64'(c16[e*16 +: 16]), 64'(tc[e]));

    // Stall at k=2 for 3 cycles, extra start at k=1, stall on the done cycle
    @(negedge clk);
    a = pk8(ta); b = pk8(tbm); accumulate = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = '1; b = '1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("stall busy_held", 64'(busy32), 64'd1);
    enable = 1'b1;
    lat = 6;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (done32) break;
    end
    chk("stall latency", 64'(lat), 64'(N + 1 + 3));
    for (int e = 0; e < 16; e++)
      chk($sformatf("stall c%0d", e), 64'(c32[e*32 +: 32]), 64'(tc[e]));
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall done_held", 64'(done32), 64'd1);
    enable = 1'b1;
    @(negedge clk);
    chk("stall done_clear", 64'(done32), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy32 || done32) seen = 1'b1;
    end
    chk("stall no_second_run", 64'(seen), 64'd0);
    $display("seq stall lat=%0d", lat);

    // Reset mid-run at k=2
    @(negedge clk);
    a = pk8(ta); b = pk8(tbm); accumulate = 1'b0; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst partial_nonzero", 64'(c32 != '0), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst busy", 64'(busy32), 64'd0);
    chk("midrst done", 64'(done32), 64'd0);
    chk("midrst ovf",  64'(ovf32),  64'd0);
    chk("midrst c_nonzero", 64'(c32 != '0), 64'd0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy32 || done32) seen = 1'b1;
    end
    chk("midrst no_done", 64'(seen), 64'd0);
    $display("seq midrun_reset");
    run(pk8(ta), pk8(tbm), 1'b0, 1'b0, "after_rst");
    for (int e = 0; e < 16; e++)
      chk($sformatf("after_rst c%0d", e), 64'(c32[e*32 +: 32]), 64'(tc[e]));

    // Random runs against the model
    for (int r = 0; r < 20; r++) begin
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      racc = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      rsm  = 1'($urandom_range(0, 1));
      run(ra, rb, racc, rsm, $sformatf("rnd%0d", r));
      model_run(ra, rb, racc, rsm);
      for (int e = 0; e < 16; e++) begin
        chk($sformatf("rnd%0d c32_%0d", r, e), 64'(c32[e*32 +: 32]), 64'(mref[0][e]));
        chk($sformatf("rnd%0d c16_%0d", r, e), 64'(c16[e*16 +: 16]), 64'(mref[1][e]));
      end
      chk($sformatf("rnd%0d ovf32", r), 64'(ovf32), 64'(mov[0]));
      chk($sformatf("rnd%0d ovf16", r), 64'(ovf16), 64'(mov[1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
